// File: rtl/clk_div_loader_if.sv
// Request/control bundle between a divisor source, clk_div_loader and CLK_GEN.
// The master side issues divisor/enable requests and supplies the divider
// overflow strobe; the slave side (clk_div_loader) returns the divider
// controls and the status pulses.
interface clk_div_loader_if #(
  parameter int RESOLUTION = 32
);
  logic [RESOLUTION-1:0] in_div;
  logic                  in_en;
  logic                  in_valid;
  logic                  in_ready;
  logic                  overflow;
  logic [RESOLUTION-1:0] div_out;
  logic                  enable_out;
  logic                  applied;
  logic                  rejected;
  logic                  timed_out;
  logic                  busy;

  modport master (
    output in_div, in_en, in_valid, overflow,
    input  in_ready, div_out, enable_out, applied, rejected, timed_out, busy
  );

  modport slave (
    input  in_div, in_en, in_valid, overflow,
    output in_ready, div_out, enable_out, applied, rejected, timed_out, busy
  );
endinterface

// File: rtl/clk_div_loader.sv
// Upstream control stage for the CLK_GEN sampling-clock divider.
// Requests are accepted over valid/ready. Illegal divisors are dropped with a
// rejected pulse. While the divider runs, a new setting is held pending and
// only written on a divider overflow edge, so the generated clock never gets
// a runt phase; a watchdog forces the write if no overflow shows up.
module clk_div_loader #(
  parameter int RESOLUTION     = 32,
  parameter int MIN_DIV        = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  clk_div_loader_if.slave   bus
);

  localparam int                    WD_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RESOLUTION-1:0] MIN_DIV_V = RESOLUTION'(MIN_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SYNC = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [RESOLUTION-1:0] div_q, div_d;
  logic                  en_q, en_d;
  logic [RESOLUTION-1:0] pend_div_q, pend_div_d;
  logic                  pend_en_q, pend_en_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  applied_q, applied_d;
  logic                  rejected_q, rejected_d;
  logic                  timed_out_q, timed_out_d;

  logic                  ready_w;
  logic                  xfer_w;
  logic                  legal_w;

  // Ready and busy are plain state decodes; only SYNC blocks new requests.
  assign ready_w = (state_q != S_SYNC);
  assign xfer_w  = bus.in_valid && ready_w;
  assign legal_w = (bus.in_div >= MIN_DIV_V);

  // State register plus all registered outputs and pending request storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      en_q        <= 1'b0;
      pend_div_q  <= '0;
      pend_en_q   <= 1'b0;
      wd_q        <= '0;
      applied_q   <= 1'b0;
      rejected_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      en_q        <= en_d;
      pend_div_q  <= pend_div_d;
      pend_en_q   <= pend_en_d;
      wd_q        <= wd_d;
      applied_q   <= applied_d;
      rejected_q  <= rejected_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Next-state logic: direct write when stopped, deferred write while running.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    en_d        = en_q;
    pend_div_d  = pend_div_q;
    pend_en_d   = pend_en_q;
    wd_d        = wd_q;
    applied_d   = 1'b0;
    rejected_d  = 1'b0;
    timed_out_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (xfer_w) begin
          if (!legal_w) begin
            rejected_d = 1'b1;
          end else begin
            div_d     = bus.in_div;
            en_d      = bus.in_en;
            applied_d = 1'b1;
            state_d   = bus.in_en ? S_RUN : S_IDLE;
          end
        end
      end

      S_RUN: begin
        // Overflow is ignored here; only a legal request moves us on.
        if (xfer_w) begin
          if (!legal_w) begin
            rejected_d = 1'b1;
          end else begin
            pend_div_d = bus.in_div;
            pend_en_d  = bus.in_en;
            wd_d       = '0;
            state_d    = S_SYNC;
          end
        end
      end

      S_SYNC: begin
        // The write lands on the same edge that CLK_GEN toggles and clears its
        // count, so the new period starts clean. An overflow on the timeout
        // edge counts as a normal overflow apply.
        if (bus.overflow || (wd_q == WD_LAST)) begin
          div_d       = pend_div_q;
          en_d        = pend_en_q;
          applied_d   = 1'b1;
          timed_out_d = !bus.overflow;
          state_d     = pend_en_q ? S_RUN : S_IDLE;
        end else if (wd_q != WD_LAST) begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = ready_w;
  assign bus.busy       = (state_q == S_SYNC);
  assign bus.div_out    = div_q;
  assign bus.enable_out = en_q;
  assign bus.applied    = applied_q;
  assign bus.rejected   = rejected_q;
  assign bus.timed_out  = timed_out_q;

endmodule

// File: tb/tb_clk_div_loader.sv
// Directed bench for clk_div_loader with a small CLK_GEN model that produces
// the overflow strobe and tracks generated half-period lengths.
module tb_clk_div_loader;

  localparam int RES = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  clk_div_loader_if #(.RESOLUTION(RES)) bus ();

  clk_div_loader #(
    .RESOLUTION    (RES),
    .MIN_DIV       (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // CLK_GEN model: count from 0, overflow when count == div>>1, then toggle and clear.
  logic [RES-1:0] cnt_q = '0;
  logic           gclk_q = 1'b0;
  int             cyc = 0;
  int             last_tg = 0;
  int             min_hp = 1000;
  logic           hp_arm = 1'b0;
  logic           ovf_force_en = 1'b0;
  logic           ovf_force_val = 1'b0;
  logic           ovf_model;

  assign ovf_model    = bus.enable_out && (cnt_q == (bus.div_out >> 1));
  assign bus.overflow = ovf_force_en ? ovf_force_val : ovf_model;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || !bus.enable_out) begin
      cnt_q   <= '0;
      gclk_q  <= 1'b0;
      last_tg <= cyc;
    end else if (ovf_model) begin
      cnt_q   <= '0;
      gclk_q  <= ~gclk_q;
      last_tg <= cyc;
      if (hp_arm && ((cyc - last_tg) < min_hp)) min_hp <= cyc - last_tg;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
    if (!hp_arm) min_hp <= 1000;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [RES-1:0] d, input logic e);
    bus.in_div   = d;
    bus.in_en    = e;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Step until applied pulses; report steps taken (-1 if never), overflow seen
  // just before the applying edge, and how many waiting cycles showed in_ready=1.
  task automatic wait_apply(input int limit, output int steps, output logic pre,
                            output int ready_seen);
    steps      = -1;
    pre        = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < limit; i++) begin
      pre = bus.overflow;
      if (bus.in_ready) ready_seen++;
      step();
      if (bus.applied) begin
        steps = i + 1;
        break;
      end
    end
  endtask

  int   steps;
  logic pre;
  int   rdy;

  initial begin
    reset        = 1'b1;
    bus.in_div   = '0;
    bus.in_en    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("rst_div",   bus.div_out, 0);
    chk("rst_en",    bus.enable_out, 0);
    chk("rst_app",   bus.applied, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy",  bus.busy, 0);
    reset = 1'b0;
    step();

    // 1: IDLE start with 1-edge latency
    send(10, 1'b1);
    chk("t1_div",   bus.div_out, 10);
    chk("t1_en",    bus.enable_out, 1);
    chk("t1_app",   bus.applied, 1);
    chk("t1_ready", bus.in_ready, 1);
    step();
    chk("t1_app_pulse", bus.applied, 0);

    // 2: illegal divisors in RUN
    send(1, 1'b1);
    chk("t2_rej_run", bus.rejected, 1);
    chk("t2_app_run", bus.applied, 0);
    chk("t2_div_run", bus.div_out, 10);
    chk("t2_busy",    bus.busy, 0);
    send(0, 1'b0);
    chk("t2_rej0",    bus.rejected, 1);
    chk("t2_en_run",  bus.enable_out, 1);

    // 3: rate change mid-period waits for overflow
    step();
    step();
    hp_arm = 1'b1;
    send(20, 1'b1);
    chk("t3_busy",  bus.busy, 1);
    chk("t3_ready", bus.in_ready, 0);
    chk("t3_hold",  bus.div_out, 10);
    wait_apply(40, steps, pre, rdy);
    chk("t3_found",   steps > 0, 1);
    chk("t3_on_ovf",  pre, 1);
    chk("t3_rdy_low", rdy, 0);
    chk("t3_div",     bus.div_out, 20);
    chk("t3_to",      bus.timed_out, 0);
    chk("t3_idle_rdy", bus.in_ready, 1);
    repeat (30) step();
    chk("t3_min_half", min_hp, 6);
    hp_arm = 1'b0;

    // 4: stop only on overflow, then restart from IDLE
    send(20, 1'b0);
    chk("t4_busy", bus.busy, 1);
    chk("t4_en_hold", bus.enable_out, 1);
    wait_apply(40, steps, pre, rdy);
    chk("t4_found",  steps > 0, 1);
    chk("t4_on_ovf", pre, 1);
    chk("t4_en",     bus.enable_out, 0);
    chk("t4_busy2",  bus.busy, 0);
    send(1, 1'b1);
    chk("t4_rej_idle", bus.rejected, 1);
    chk("t4_rej_en",   bus.enable_out, 0);
    chk("t4_rej_div",  bus.div_out, 20);
    send(8, 1'b1);
    chk("t4_div", bus.div_out, 8);
    chk("t4_en2", bus.enable_out, 1);
    chk("t4_app", bus.applied, 1);

    // 5: watchdog with overflow held low, then coincident overflow
    ovf_force_en  = 1'b1;
    ovf_force_val = 1'b0;
    send(30, 1'b1);
    chk("t5_busy", bus.busy, 1);
    wait_apply(40, steps, pre, rdy);
    chk("t5_steps", steps, 16);
    chk("t5_to",    bus.timed_out, 1);
    chk("t5_div",   bus.div_out, 30);
    chk("t5_en",    bus.enable_out, 1);
    step();
    chk("t5_to_pulse", bus.timed_out, 0);
    send(40, 1'b1);
    repeat (15) step();
    chk("t5_wait", bus.applied, 0);
    ovf_force_val = 1'b1;
    step();
    ovf_force_val = 1'b0;
    chk("t5c_app", bus.applied, 1);
    chk("t5c_to",  bus.timed_out, 0);
    chk("t5c_div", bus.div_out, 40);
    ovf_force_val = 1'b1;
    step();
    ovf_force_val = 1'b0;
    chk("t5_run_ovf_app",  bus.applied, 0);
    chk("t5_run_ovf_busy", bus.busy, 0);

    // 6: reset during SYNC with a held request
    send(50, 1'b1);
    bus.in_div   = 60;
    bus.in_en    = 1'b1;
    bus.in_valid = 1'b1;
    step();
    step();
    chk("t6_busy", bus.busy, 1);
    chk("t6_div",  bus.div_out, 40);
    reset = 1'b1;
    #1;
    chk("t6_rst_div",   bus.div_out, 0);
    chk("t6_rst_en",    bus.enable_out, 0);
    chk("t6_rst_busy",  bus.busy, 0);
    chk("t6_rst_ready", bus.in_ready, 1);
    step();
    reset = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("t6_acc_div", bus.div_out, 60);
    chk("t6_acc_en",  bus.enable_out, 1);
    chk("t6_acc_app", bus.applied, 1);
    ovf_force_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
